// File: rtl/regfile_pkg.sv
// Shared constants and types for the multiport register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned AW_DEF   = 5;

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;

  // Address of the optional hardwired-zero register.
  localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one pending bit per register plus an incremental
// popcount. A set and a clear of the same register in one cycle resolves to set.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned NQ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en_i,
  input  logic [AW-1:0]    set_addr_i,
  input  logic             clr_en_i,
  input  logic [AW-1:0]    clr_addr_i,
  input  logic [NQ*AW-1:0] qaddr_i,
  output logic [NQ-1:0]    busy_o,
  output logic [AW:0]      pend_cnt_o
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DEPTH-1:0] pending_q, pending_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             inc, dec;

  // Next pending vector: clear first, then set so a new producer wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_en_i) pending_d[clr_addr_i] = 1'b0;
    if (set_en_i) pending_d[set_addr_i] = 1'b1;
  end

  // Count delta mirrors the bit transitions of pending_d versus pending_q.
  always_comb begin
    inc   = set_en_i && !pending_q[set_addr_i];
    dec   = clr_en_i && pending_q[clr_addr_i] && !(set_en_i && (set_addr_i == clr_addr_i));
    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + (AW + 1)'(1);
    end else if (dec && !inc) begin
      cnt_d = cnt_q - (AW + 1)'(1);
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  for (genvar g = 0; g < NQ; g++) begin : g_query
    assign busy_o[g] = pending_q[qaddr_i[g*AW +: AW]];
  end

  assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multiport register file with pending-write scoreboard.
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we3_i,
  input  logic [AW-1:0]          a3_i,
  input  logic [XLEN-1:0]        wd3_i,
  input  logic [NUM_RD*AW-1:0]   ra_i,
  output logic [NUM_RD*XLEN-1:0] rd_o,
  output logic [NUM_RD-1:0]      rd_busy_o,
  input  logic                   iss_valid_i,
  input  logic [AW-1:0]          iss_rd_i,
  output logic [AW:0]            pend_cnt_o
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [XLEN-1:0]   mem_q [DEPTH];
  logic              vw, vi;
  logic [NUM_RD-1:0] sb_busy;

  // Writes and issues to the hardwired-zero register are dropped here so the
  // scoreboard never sees them.
  assign vw = rst_n && we3_i && !(ZERO_REG && (a3_i == AW'(ZERO_ADDR)));
  assign vi = rst_n && iss_valid_i && !(ZERO_REG && (iss_rd_i == AW'(ZERO_ADDR)));

  // Storage array with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (vw) begin
      mem_q[a3_i] <= wd3_i;
    end
  end

  regfile_scoreboard #(
    .AW (AW),
    .NQ (NUM_RD)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en_i   (vi),
    .set_addr_i (iss_rd_i),
    .clr_en_i   (vw),
    .clr_addr_i (a3_i),
    .qaddr_i    (ra_i),
    .busy_o     (sb_busy),
    .pend_cnt_o (pend_cnt_o)
  );

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = ra_i[g*AW +: AW];

    // Per-port read mux, optional bypass, then zero-register override.
    always_comb begin
      data = mem_q[addr];
      busy = sb_busy[g];
`ifdef REGFILE_BYPASS_EN
      if (vw && (a3_i == addr)) begin
        data = wd3_i;
        busy = vi && (iss_rd_i == a3_i);
      end
`endif
      if (ZERO_REG && (addr == AW'(ZERO_ADDR))) begin
        data = '0;
        busy = 1'b0;
      end
    end

    // Outputs are forced low for the whole time reset is asserted.
    assign rd_o[g*XLEN +: XLEN] = rst_n ? data : '0;
    assign rd_busy_o[g]         = rst_n && busy;
  end

endmodule
